// File: rtl/serial_mod_checker_pkg.sv
// Shared types and width helpers for the bit-serial divisibility checker.
package serial_mod_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, SAT} state_e;
  typedef enum logic {MSB_FIRST, LSB_FIRST} mode_e;

  // Remainder width for modulus n; a 1-bit floor keeps n==2 representable.
  function automatic int rem_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_mod_checker_if.sv
// Serial input bus and registered result bus of the divisibility checker.
interface serial_mod_checker_if
  import serial_mod_pkg::*;
#(
  parameter int DIVISOR  = 5,
  parameter int MAX_BITS = 32
) ();

  localparam int RW = rem_width(DIVISOR);
  localparam int CW = $clog2(MAX_BITS + 1);

  logic          clr;
  logic          in_valid;
  logic          in_bit;
  logic          lsb_first;
  logic          out;
  logic [RW-1:0] rem;
  logic [CW-1:0] bit_cnt;
  logic          out_valid;
  logic          overflow;

  modport master (
    output clr, in_valid, in_bit, lsb_first,
    input  out, rem, bit_cnt, out_valid, overflow
  );

  modport slave (
    input  clr, in_valid, in_bit, lsb_first,
    output out, rem, bit_cnt, out_valid, overflow
  );

endinterface

// File: rtl/serial_mod_checker_mod_step.sv
// Modular add: (a + addend) reduced by one conditional subtract of N; needs a < N, addend <= N.
module mod_step #(
  parameter int W = 3,
  parameter int N = 5
) (
  input  logic [W-1:0] a,
  input  logic [W:0]   addend,
  output logic [W-1:0] y
);

  localparam logic [W+1:0] NV = (W+2)'(N);

  logic [W+1:0] sum;

  assign sum = {2'b00, a} + {1'b0, addend};
  assign y   = W'((sum >= NV) ? (sum - NV) : sum);

endmodule

// File: rtl/serial_mod_checker.sv
// Bit-serial divisibility checker: running remainder mod DIVISOR with MSB/LSB-first order.
module serial_mod_checker
  import serial_mod_pkg::*;
#(
  parameter int DIVISOR  = 5,
  parameter int MAX_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_mod_checker_if.slave  bus
);

  localparam int RW = rem_width(DIVISOR);
  localparam int CW = $clog2(MAX_BITS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BITS);
  localparam logic [RW-1:0] ONE     = RW'(1);

  if (DIVISOR < 2 || DIVISOR > 255) begin : g_bad_divisor
    $error("serial_mod_checker: DIVISOR must be in 2..255");
  end
  if (MAX_BITS < 1) begin : g_bad_max_bits
    $error("serial_mod_checker: MAX_BITS must be >= 1");
  end

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == MAX_CNT) ? c : c + 1'b1;
  endfunction

  state_e        state, state_nxt;
  mode_e         mode_p1, mode_nxt;
  logic [RW-1:0] rem_p1, rem_nxt;
  logic [RW-1:0] weight_p1, weight_nxt;
  logic [CW-1:0] cnt_p1, cnt_nxt;
  logic          out_p1, out_nxt;
  logic          vld_p1, vld_nxt;
  logic          ovf_p1, ovf_nxt;

  logic          frame_start;
  mode_e         base_mode;
  logic [RW-1:0] base_rem, base_w;
  logic [CW-1:0] base_cnt, cnt_inc;
  logic [RW:0]   rem_add;
  logic [RW-1:0] rem_step, w_step;

  // A bit arriving with clr or in IDLE opens a new frame from the reset values.
  assign frame_start = bus.clr || (state == IDLE);
  assign base_rem    = frame_start ? '0 : rem_p1;
  assign base_w      = frame_start ? ONE : weight_p1;
  assign base_mode   = frame_start ? mode_e'(bus.lsb_first) : mode_p1;
  assign base_cnt    = bus.clr ? '0 : cnt_p1;
  assign cnt_inc     = sat_inc(base_cnt);

  // MSB-first: 2*rem + b = rem + (rem + b); LSB-first: rem + b*weight.
  assign rem_add = (base_mode == MSB_FIRST) ? ({1'b0, base_rem} + {{RW{1'b0}}, bus.in_bit})
                                            : (bus.in_bit ? {1'b0, base_w} : '0);

  mod_step #(.W(RW), .N(DIVISOR)) u_rem_step (
    .a      (base_rem),
    .addend (rem_add),
    .y      (rem_step)
  );

  mod_step #(.W(RW), .N(DIVISOR)) u_weight_step (
    .a      (base_w),
    .addend ({1'b0, base_w}),
    .y      (w_step)
  );

  always_comb begin
    state_nxt  = state;
    mode_nxt   = mode_p1;
    rem_nxt    = rem_p1;
    weight_nxt = weight_p1;
    cnt_nxt    = cnt_p1;
    out_nxt    = out_p1;
    vld_nxt    = 1'b0;
    ovf_nxt    = ovf_p1;
    if (bus.clr) begin
      state_nxt  = IDLE;
      rem_nxt    = '0;
      weight_nxt = ONE;
      cnt_nxt    = '0;
      out_nxt    = 1'b0;
      ovf_nxt    = 1'b0;
    end
    if (bus.in_valid) begin
      mode_nxt   = base_mode;
      rem_nxt    = rem_step;
      weight_nxt = w_step;
      cnt_nxt    = cnt_inc;
      out_nxt    = (rem_step == '0);
      vld_nxt    = 1'b1;
      ovf_nxt    = (bus.clr ? 1'b0 : ovf_p1) | (base_cnt == MAX_CNT);
      state_nxt  = (cnt_inc == MAX_CNT) ? SAT : ACCUM;
    end
  end

  // ---- registered output stage ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_p1   <= MSB_FIRST;
      rem_p1    <= '0;
      weight_p1 <= ONE;
      cnt_p1    <= '0;
      out_p1    <= 1'b0;
      vld_p1    <= 1'b0;
      ovf_p1    <= 1'b0;
    end else begin
      state     <= state_nxt;
      mode_p1   <= mode_nxt;
      rem_p1    <= rem_nxt;
      weight_p1 <= weight_nxt;
      cnt_p1    <= cnt_nxt;
      out_p1    <= out_nxt;
      vld_p1    <= vld_nxt;
      ovf_p1    <= ovf_nxt;
    end
  end

  assign bus.out       = out_p1;
  assign bus.rem       = rem_p1;
  assign bus.bit_cnt   = cnt_p1;
  assign bus.out_valid = vld_p1;
  assign bus.overflow  = ovf_p1;

endmodule

// File: tb/tb_serial_mod_checker.sv
// Scoreboard bench: two checkers (N=5/MAX=32 and N=7/MAX=4) share one randomized serial stream.
module tb_serial_mod_checker;

  typedef struct {
    int rem;
    int cnt;
    bit out;
    bit ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  serial_mod_checker_if #(.DIVISOR(5), .MAX_BITS(32)) bus0 ();
  serial_mod_checker_if #(.DIVISOR(7), .MAX_BITS(4))  bus1 ();

  serial_mod_checker #(.DIVISOR(5), .MAX_BITS(32)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  serial_mod_checker #(.DIVISOR(7), .MAX_BITS(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  always #5 clk = ~clk;

  // Reference model: the frame is kept as its list of bits; results come from plain arithmetic.
  bit   frame[$];
  bit   mode_lsb;
  bit   acc_last;
  bit   mon_en = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad = 0;

  function automatic int calc_rem(input int n);
    int r = 0;
    int w = 1;
    foreach (frame[i]) begin
      if (!mode_lsb) r = (r * 2 + int'(frame[i])) % n;
      else begin
        r = (r + int'(frame[i]) * w) % n;
        w = (w * 2) % n;
      end
    end
    return r;
  endfunction

  function automatic exp_t expect_for(input int n, input int mx);
    exp_t e;
    e.rem = calc_rem(n);
    e.cnt = (frame.size() > mx) ? mx : frame.size();
    e.out = (frame.size() > 0) && (e.rem == 0);
    e.ovf = frame.size() > mx;
    return e;
  endfunction

  task automatic step(input bit r_n, input bit c, input bit v, input bit b, input bit l);
    rst_n = r_n;
    bus0.clr = c;  bus0.in_valid = v;  bus0.in_bit = b;  bus0.lsb_first = l;
    bus1.clr = c;  bus1.in_valid = v;  bus1.in_bit = b;  bus1.lsb_first = l;
    @(posedge clk);
    acc_last = 1'b0;
    if (!r_n) begin
      frame.delete();
      mode_lsb = 1'b0;
    end else begin
      if (c) frame.delete();
      if (v) begin
        if (frame.size() == 0) mode_lsb = l;
        frame.push_back(b);
        acc_last = 1'b1;
        q0.push_back(expect_for(5, 32));
        q1.push_back(expect_for(7, 4));
      end
    end
    #1;
  endtask

  task automatic cmp(input string name, input int k, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s[dut%0d] got=%0d want=%0d (t=%0t)", name, k, got, want, $time);
    end
  endtask

  task automatic check(input int k, input bit ov, input int r, input int c, input bit o,
                       input bit f);
    exp_t e;
    cmp("out_valid", k, int'(ov), int'(acc_last));
    if (ov) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        total++;
        bad++;
        $display("FAIL scoreboard[dut%0d] got=out_valid want=no_pending_result", k);
        return;
      end
      e = (k == 0) ? q0.pop_front() : q1.pop_front();
    end else begin
      e = (k == 0) ? expect_for(5, 32) : expect_for(7, 4);
    end
    cmp("rem", k, r, e.rem);
    cmp("bit_cnt", k, c, e.cnt);
    cmp("out", k, int'(o), int'(e.out));
    cmp("overflow", k, int'(f), int'(e.ovf));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check(0, bus0.out_valid, int'(bus0.rem), int'(bus0.bit_cnt), bus0.out, bus0.overflow);
      check(1, bus1.out_valid, int'(bus1.rem), int'(bus1.bit_cnt), bus1.out, bus1.overflow);
    end
  end

  initial begin
    bit b;
    bit l;
    bit [5:0] pat;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;

    // MSB-first 1,0,1,0,1,0 (value 42)
    pat = 6'b101010;
    for (int i = 5; i >= 0; i--) step(1'b1, 1'b0, 1'b1, pat[i], 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // clr alone with LSB-first requested, then 1,0,1 while lsb_first toggles mid-frame
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    // Gapped MSB-first 1,1,1,1 with two idle cycles between bits
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    end

    // clr together with a bit mid-frame, then reset while a bit is offered
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Five ones: saturates the MAX_BITS=4 checker; clr then clears overflow
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Long frames past 32 bits in both orders
    for (int m = 0; m < 2; m++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'(m));
      for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'(m));
    end

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      b = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1));
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 9) < 6), b, l);
    end

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    cmp("pending_dut0", 0, q0.size(), 0);
    cmp("pending_dut1", 1, q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
